// File: rtl/reflet_float_pkg.sv
// Shared definitions for the reflet floating-point units (divider, multiplier).
// Holds the IEEE-754 single-precision field widths, canonical constants,
// operand classes and the divider state encoding.
package reflet_float_pkg;

  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;
  localparam int FLT_BIAS  = 127;

  localparam logic [31:0] FLT_CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] FLT_POS_INF   = 32'h7F800000;

  typedef enum logic [1:0] {
    FLT_ZERO,
    FLT_NORMAL,
    FLT_INF,
    FLT_NAN
  } flt_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_ROUND,
    ST_DONE
  } div_state_t;

  function automatic logic [31:0] fltSignedInf(input logic sign);
    return {sign, FLT_POS_INF[30:0]};
  endfunction

  function automatic logic [31:0] fltSignedZero(input logic sign);
    return {sign, 31'd0};
  endfunction

endpackage

// File: rtl/reflet_float_unpack.sv
// Combinational unpacker for IEEE-754 single-precision values.
// Splits a float into sign, biased exponent and 24-bit mantissa with the
// hidden bit restored, and classifies it. Denormals are flushed to zero.
module reflet_float_unpack
  import reflet_float_pkg::*;
(
  input  logic [31:0] f_i,
  output logic        sign_o,
  output logic [7:0]  exp_o,
  output logic [23:0] man_o,
  output logic [1:0]  cls_o
);

  logic [FLT_EXP_W-1:0] expRaw;
  logic [FLT_MAN_W-1:0] frac;

  assign expRaw = f_i[30:FLT_MAN_W];
  assign frac   = f_i[FLT_MAN_W-1:0];

  // Classify the operand; exponent 0 covers both true zero and flushed denormals.
  always_comb begin
    sign_o = f_i[31];
    exp_o  = expRaw;
    man_o  = {1'b1, frac};
    cls_o  = FLT_NORMAL;
    if (expRaw == 8'hFF) begin
      cls_o = (frac != '0) ? FLT_NAN : FLT_INF;
      man_o = {1'b0, frac};
    end else if (expRaw == 8'h00) begin
      cls_o = FLT_ZERO;
      exp_o = 8'h00;
      man_o = 24'd0;
    end
  end

endmodule

// File: rtl/reflet_float_div.sv
// Sequential IEEE-754 single-precision divider: div = in1 / in2.
// Restoring radix-2 mantissa division producing iter_per_cycle quotient bits
// per clock, round-to-nearest-even, flush-to-zero on denormal inputs/results.
// Optional exception flags port enabled by the macro REFLET_FLOAT_DIV_FLAGS_EN.
module reflet_float_div
  import reflet_float_pkg::*;
#(
  parameter int iter_per_cycle = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] div,
  output logic        ready
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  localparam int         DIV_CYCLES = 26 / iter_per_cycle;
  localparam logic [4:0] LAST_CNT   = 5'(DIV_CYCLES - 1);

  div_state_t  state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] div_q, div_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;
  logic [23:0] divisor_q, divisor_d;
  logic [25:0] rem_q, rem_d;
  logic [25:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
  logic [3:0]  flags_q, flags_d;
`endif

  logic        s1, s2;
  logic [7:0]  e1, e2;
  logic [23:0] m1, m2;
  logic [1:0]  c1, c2;

  logic        inputsDiffer;
  logic        signRes;
  logic [9:0]  expLoad;
  logic [25:0] remWork;
  logic [25:0] quotWork;
  logic        roundUp;
  logic [24:0] mantRnd;
  logic [23:0] mantFinal;
  logic [9:0]  expRnd;

  reflet_float_unpack unpackOp1 (
    .f_i    (op1_q),
    .sign_o (s1),
    .exp_o  (e1),
    .man_o  (m1),
    .cls_o  (c1)
  );

  reflet_float_unpack unpackOp2 (
    .f_i    (op2_q),
    .sign_o (s2),
    .exp_o  (e2),
    .man_o  (m2),
    .cls_o  (c2)
  );

  assign inputsDiffer = (in1 != op1_q) || (in2 != op2_q);
  assign signRes      = s1 ^ s2;
  assign expLoad      = {2'b00, e1} - {2'b00, e2} + 10'(FLT_BIAS);

  // Datapath helpers: one cycle of restoring division steps and the RNE rounding of the final quotient.
  always_comb begin
    remWork  = rem_q;
    quotWork = quot_q;
    for (int i = 0; i < iter_per_cycle; i++) begin
      if (remWork >= {2'b00, divisor_q}) begin
        remWork  = (remWork - {2'b00, divisor_q}) << 1;
        quotWork = {quotWork[24:0], 1'b1};
      end else begin
        remWork  = remWork << 1;
        quotWork = {quotWork[24:0], 1'b0};
      end
    end
    roundUp   = quot_q[1] & (quot_q[0] | (rem_q != 26'd0) | quot_q[2]);
    mantRnd   = {1'b0, quot_q[25:2]} + {24'd0, roundUp};
    mantFinal = mantRnd[23:0];
    expRnd    = exp_q;
    if (mantRnd[24]) begin
      mantFinal = mantRnd[24:1];
      expRnd    = exp_q + 10'd1;
    end
  end

  // Next-state logic: capture/restart on operand change, special cases in LOAD, iterate, round, hold in DONE.
  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    div_d     = div_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
    flags_d   = flags_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_IDLE) || inputsDiffer) begin
      op1_d   = in1;
      op2_d   = in2;
      state_d = ST_LOAD;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
      flags_d = 4'b0000;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ST_DONE;
          if ((c1 == FLT_NAN) || (c2 == FLT_NAN) ||
              ((c1 == FLT_ZERO) && (c2 == FLT_ZERO)) ||
              ((c1 == FLT_INF) && (c2 == FLT_INF))) begin
            div_d = FLT_CANON_NAN;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
            flags_d = 4'b1000;
`endif
          end else if (c1 == FLT_INF) begin
            div_d = fltSignedInf(signRes);
          end else if (c2 == FLT_ZERO) begin
            div_d = fltSignedInf(signRes);
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
            flags_d = 4'b0100;
`endif
          end else if ((c2 == FLT_INF) || (c1 == FLT_ZERO)) begin
            div_d = fltSignedZero(signRes);
          end else begin
            state_d   = ST_DIV;
            sign_d    = signRes;
            divisor_d = m2;
            quot_d    = 26'd0;
            cnt_d     = 5'd0;
            if (m1 < m2) begin
              rem_d = {1'b0, m1, 1'b0};
              exp_d = expLoad - 10'd1;
            end else begin
              rem_d = {2'b00, m1};
              exp_d = expLoad;
            end
          end
        end
        ST_DIV: begin
          rem_d  = remWork;
          quot_d = quotWork;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_d = ST_DONE;
          if ($signed(expRnd) >= 10'sd255) begin
            div_d = fltSignedInf(sign_q);
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
            flags_d = 4'b0010;
`endif
          end else if ($signed(expRnd) <= 10'sd0) begin
            div_d = fltSignedZero(sign_q);
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
            flags_d = 4'b0001;
`endif
          end else begin
            div_d = {sign_q, expRnd[7:0], mantFinal[22:0]};
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      div_q     <= 32'd0;
      sign_q    <= 1'b0;
      exp_q     <= 10'd0;
      divisor_q <= 24'd0;
      rem_q     <= 26'd0;
      quot_q    <= 26'd0;
      cnt_q     <= 5'd0;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
      flags_q   <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      div_q     <= div_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
      flags_q   <= flags_d;
`endif
    end
  end

  assign div   = div_q;
  assign ready = (state_q == ST_DONE) && !inputsDiffer;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_reflet_float_div.sv
// Testbench for reflet_float_div: runs a 1-bit/cycle and a 2-bit/cycle
// instance side by side on the same inputs, checks a table of known
// quotients, randomized operands against an integer reference model, and
// hand-written restart / reset / enable sequences.
// Flag checks are compiled in when REFLET_FLOAT_DIV_FLAGS_EN is defined.
module tb_reflet_float_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] div1, div2;
  logic        ready1, ready2;
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
  logic [3:0]  flags1, flags2;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expDiv;
    logic [3:0]  expFlags;
    string       name;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  reflet_float_div #(.iter_per_cycle(1)) dutIter1 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in1    (in1),
    .in2    (in2),
    .div    (div1),
    .ready  (ready1)
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
    ,
    .flags  (flags1)
`endif
  );

  reflet_float_div #(.iter_per_cycle(2)) dutIter2 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in1    (in1),
    .in2    (in2),
    .div    (div2),
    .ready  (ready2)
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
    ,
    .flags  (flags2)
`endif
  );

  // Reference quotient: exact integer division of the mantissas, then RNE and range checks.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic [3:0] flg,
                                 output bit special);
    int ea, eb, e, top, sh;
    bit za, zb, ia, ib, na, nb;
    logic s;
    logic [63:0] ma, mb, num, q, r, mant, rest, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    s = a[31] ^ b[31];
    flg = 4'b0000;
    special = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      res = 32'h7FC00000;
      flg = 4'b1000;
      return;
    end
    if (ia) begin
      res = {s, 8'hFF, 23'd0};
      return;
    end
    if (zb) begin
      res = {s, 8'hFF, 23'd0};
      flg = 4'b0100;
      return;
    end
    if (ib || za) begin
      res = {s, 31'd0};
      return;
    end
    special = 1'b0;
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    num = ma << 32;
    q = num / mb;
    r = num % mb;
    top = (q >= (64'd1 << 32)) ? 32 : 31;
    e = ea - eb + 127 + (top - 32);
    sh = top - 23;
    mant = q >> sh;
    rest = q & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if ((rest > half) || ((rest == half) && ((r != 64'd0) || mant[0]))) mant = mant + 64'd1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'd0};
      flg = 4'b0010;
    end else if (e <= 0) begin
      res = {s, 31'd0};
      flg = 4'b0001;
    end else begin
      res = {s, e[7:0], mant[22:0]};
    end
  endfunction

  function automatic logic [31:0] randOperand();
    logic [7:0] e;
    int pick;
    pick = int'($urandom_range(0, 9));
    if (pick == 0)      e = 8'($urandom_range(1, 20));
    else if (pick == 1) e = 8'($urandom_range(235, 254));
    else                e = 8'($urandom_range(90, 165));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drop enable for one edge so every operation starts from IDLE, then present the operands.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    in1 = a;
    in2 = b;
    enable = 1'b1;
  endtask

  // Wait for the capture edge, then count edges until each instance raises ready (bounded).
  task automatic waitReady(output int lat1, output int lat2);
    lat1 = -1;
    lat2 = -1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if ((lat1 < 0) && ready1) lat1 = k;
      if ((lat2 < 0) && ready2) lat2 = k;
      if ((lat1 >= 0) && (lat2 >= 0)) break;
    end
  endtask

  task automatic checkResult(input string name, input logic [31:0] expDiv,
                             input logic [3:0] expFlags, input bit special,
                             input int lat1, input int lat2);
    checkOutput($sformatf("%s div_it1", name), div1, expDiv);
    checkOutput($sformatf("%s div_it2", name), div2, expDiv);
    checkOutput($sformatf("%s latency_it1", name), 32'(lat1), special ? 32'd1 : 32'd28);
    checkOutput($sformatf("%s latency_it2", name), 32'(lat2), special ? 32'd1 : 32'd15);
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
    checkOutput($sformatf("%s flags_it1", name), {28'd0, flags1}, {28'd0, expFlags});
    checkOutput($sformatf("%s flags_it2", name), {28'd0, flags2}, {28'd0, expFlags});
`else
    if (expFlags === 4'bxxxx) $display("[TB] unexpected unknown flag expectation for %s", name);
`endif
  endtask

  task automatic runCase(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expDiv, input logic [3:0] expFlags);
    logic [31:0] modelRes;
    logic [3:0]  modelFlags;
    bit          special;
    int          lat1, lat2;
    refDiv(a, b, modelRes, modelFlags, special);
    applyStimulus(a, b);
    waitReady(lat1, lat2);
    checkResult(name, expDiv, expFlags, special, lat1, lat2);
  endtask

  initial begin
    logic [31:0] a, b, expRes;
    logic [3:0]  expFlg;
    bit          special;
    int          lat1, lat2;

    vecs[0]  = '{32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, "six_by_three"};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, "one_by_three"};
    vecs[2]  = '{32'hC1E00000, 32'h41700000, 32'hBFEEEEEF, 4'b0000, "m28_by_15"};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, "one_by_zero"};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, "zero_by_zero"};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, "overflow"};
    vecs[6]  = '{32'h00800000, 32'h41000000, 32'h00000000, 4'b0001, "underflow"};
    vecs[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, "nan_by_one"};
    vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, "inf_by_inf"};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "ninf_by_two"};
    vecs[10] = '{32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, "two_by_ninf"};
    vecs[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, "nzero_by_two"};
    vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, "denorm_dividend"};
    vecs[13] = '{32'h3F800000, 32'h80000001, 32'hFF800000, 4'b0100, "denorm_divisor"};
    vecs[14] = '{32'h40400000, 32'h3F800000, 32'h40400000, 4'b0000, "three_by_one"};

    reset  = 1'b1;
    enable = 1'b0;
    in1    = 32'd0;
    in2    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset div_it1", div1, 32'd0);
    checkOutput("reset div_it2", div2, 32'd0);
    checkOutput("reset ready_it1", {31'd0, ready1}, 32'd0);
    checkOutput("reset ready_it2", {31'd0, ready2}, 32'd0);
`ifdef REFLET_FLOAT_DIV_FLAGS_EN
    checkOutput("reset flags_it1", {28'd0, flags1}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      runCase(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].expDiv, vecs[i].expFlags);
    end

    for (int i = 0; i < 40; i++) begin
      a = randOperand();
      b = randOperand();
      refDiv(a, b, expRes, expFlg, special);
      runCase($sformatf("random%0d %h/%h", i, a, b), a, b, expRes, expFlg);
    end

    // Restart: change the divisor ten cycles into DIV; old operation is discarded.
    applyStimulus(32'h40C00000, 32'h40400000);
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("mid_div ready_it1", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    in2 = 32'h41700000;
    #1;
    checkOutput("restart ready_it1", {31'd0, ready1}, 32'd0);
    checkOutput("restart ready_it2", {31'd0, ready2}, 32'd0);
    refDiv(32'h40C00000, 32'h41700000, expRes, expFlg, special);
    waitReady(lat1, lat2);
    checkResult("restart", expRes, expFlg, special, lat1, lat2);
    checkOutput("restart value", div1, 32'h3ECCCCCD);

    // In DONE, ready drops combinationally when an input changes and returns when it is restored.
    @(negedge clk);
    in1 = 32'h3F800000;
    #1;
    checkOutput("input_glitch ready_it1", {31'd0, ready1}, 32'd0);
    checkOutput("input_glitch ready_it2", {31'd0, ready2}, 32'd0);
    #1;
    in1 = 32'h40C00000;
    @(posedge clk);
    #1;
    checkOutput("restored ready_it1", {31'd0, ready1}, 32'd1);

    // Enable low in DONE: ready clears, div keeps its last value.
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("disable ready_it1", {31'd0, ready1}, 32'd0);
    checkOutput("disable ready_it2", {31'd0, ready2}, 32'd0);
    checkOutput("disable div_it1", div1, 32'h3ECCCCCD);
    checkOutput("disable div_it2", div2, 32'h3ECCCCCD);

    // Reset pulse mid-DIV clears the result; afterwards the held inputs are recomputed.
    applyStimulus(32'h3F800000, 32'h40400000);
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset div_it1", div1, 32'd0);
    checkOutput("midreset div_it2", div2, 32'd0);
    checkOutput("midreset ready_it1", {31'd0, ready1}, 32'd0);
    checkOutput("midreset ready_it2", {31'd0, ready2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitReady(lat1, lat2);
    checkResult("after_reset", 32'h3EAAAAAB, 4'b0000, 1'b0, lat1, lat2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
